aes_leak_guard: RTL and testbench
=================================

# aes_leak_guard

Parametrised output guard between a block-cipher core and its output register. It watches every valid ciphertext word for three conditions: a key leak (word equals the live key), a match against a small bank of software-loaded watch patterns, and a stuck output (the same word repeated). On any detection it forces the output to zero, raises a sticky alarm and logs the event. It is the run-time countermeasure instantiated around each cipher core in the AES benches.

## Interface
Parameters:
- WIDTH, 128, data/key word width in bits
- NPAT, 4, number of watch-pattern slots (1..16)
- CNT_W, 16, width of the event counter
- STUCK_N, 8, consecutive identical valid words that flag a stuck output (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key  in  WIDTH  live key, compared against every valid din
- din  in  WIDTH  cipher output word
- din_valid  in  1  din qualifier
- dout  out  WIDTH  guarded output, registered
- dout_valid  out  1  dout qualifier
- pat_we  in  1  pattern-slot write strobe
- pat_idx  in  $clog2(NPAT) (min 1)  slot index for the write
- pat_data  in  WIDTH  pattern value to write
- pat_en  in  NPAT  per-slot compare enable
- alarm_clr  in  1  clears alarm and src
- alarm  out  1  sticky detection flag
- alarm_src  out  3  sticky cause bits {stuck, pattern, leak}
- last_idx  out  $clog2(NPAT) (min 1)  lowest-numbered matching slot of the most recent pattern hit
- event_cnt  out  CNT_W  count of valid words that caused any detection, saturating
- stuck  out  1  level flag: current run of identical words >= STUCK_N

## Operation
- Detection is evaluated only when din_valid=1:
  - leak: din==key.
  - pattern: din==pat[i] && pat_en[i] for any i.
  - stuck: run length >= STUCK_N after including this word.
- Run counter:
  - Reset value 0.
  - A valid word equal to the previous valid word increments the counter, saturating at STUCK_N.
  - A differing valid word loads 1. The first valid word after reset loads 1.
  - Invalid cycles leave the counter and the previous word unchanged.
- Pattern bank:
  - NPAT registers, reset to 0.
  - pat_we writes pat_data to slot pat_idx at the clock edge.
  - A compare in the same cycle uses the old slot value.
  - pat_idx >= NPAT: the write is ignored.
- Masking:
  - dout = 0 when the current word is a detection, or when alarm is already 1.
  - Otherwise dout = din.
  - dout_valid follows din_valid with one cycle of latency, whether or not the word is masked.
- Alarm:
  - Any detection sets alarm and ORs the cause bits into alarm_src.
  - alarm_clr clears both. If alarm_clr and a detection occur in the same cycle, the detection wins: alarm=1 and alarm_src holds only the new causes.
- last_idx updates only on a pattern hit.
- event_cnt increments once per detecting word, whatever the number of causes, and saturates at 2^CNT_W-1. It is cleared only by rst.
- rst mid-stream: all state returns to reset values immediately. This includes the run counter and the previous-word register, but not the key input.

## Timing
- All outputs are registered. Detection in the cycle-N din is visible on dout, dout_valid, alarm, alarm_src, last_idx, event_cnt and stuck at the edge ending cycle N.
- Reset values are 0 for every output: dout, dout_valid, alarm, alarm_src, last_idx, event_cnt and stuck.
- The block has no backpressure. One word per cycle is accepted at full rate.
- Masking of the current word is decided combinationally from din, key, the patterns and alarm before the output register. There is no extra latency.
- A pattern written in cycle N is first compared in cycle N+1.
- stuck deasserts one cycle after the first differing valid word.

## Test plan
- Reset with din_valid=1 held → all outputs 0; after release, din=0x1234 with key=0xAA.. → dout=0x1234 one cycle later, alarm=0, event_cnt=0.
- Leak: din==key=128'h000102..0f → dout=0, alarm=1, alarm_src=3'b001, event_cnt=1. The next clean word is also masked to 0 until alarm_clr is pulsed, then passes through.
- Pattern slot 2 = 128'h6939b2e898f969350967325782ecc94e with pat_en=4'b0100; present that word → dout=0, alarm_src=3'b010, last_idx=2. With pat_en=0 the same word passes unmasked.
- Stuck: STUCK_N=8, eight identical valid words with invalid gaps in between → stuck=1 and alarm_src[2]=1 after the 8th word only; a differing word drops stuck the next cycle.
- Simultaneous alarm_clr and leak → alarm stays 1 with alarm_src=3'b001. A pat_we to slot 0 in the same cycle as a matching din → no hit that cycle, hit on the next.
- CNT_W=2: five leak words → event_cnt saturates at 3. Assert rst mid-run → all outputs 0 on the next sample.

Source files
------------

// File: rtl/aes_leak_guard.sv
// Output guard for a block-cipher core: masks key leaks, watched patterns and
// stuck output words, latching a sticky alarm and logging each detection.

module aes_leak_guard_slot #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             en_i,
    output logic             hit_o
);
    logic [WIDTH-1:0] pat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pat_q <= '0;
        else if (we_i) pat_q <= wdata_i;
    end

    // Compare sees the pre-write value, so a new pattern is live next cycle.
    assign hit_o = en_i && (din_i == pat_q);
endmodule

module aes_leak_guard #(
    parameter int WIDTH   = 128,
    parameter int NPAT    = 4,
    parameter int CNT_W   = 16,
    parameter int STUCK_N = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [WIDTH-1:0]                       key,
    input  logic [WIDTH-1:0]                       din,
    input  logic                                   din_valid,
    output logic [WIDTH-1:0]                       dout,
    output logic                                   dout_valid,
    input  logic                                   pat_we,
    input  logic [((NPAT > 1) ? $clog2(NPAT) : 1)-1:0] pat_idx,
    input  logic [WIDTH-1:0]                       pat_data,
    input  logic [NPAT-1:0]                        pat_en,
    input  logic                                   alarm_clr,
    output logic                                   alarm,
    output logic [2:0]                             alarm_src,
    output logic [((NPAT > 1) ? $clog2(NPAT) : 1)-1:0] last_idx,
    output logic [CNT_W-1:0]                       event_cnt,
    output logic                                   stuck
);
    localparam int IW = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int RW = $clog2(STUCK_N + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STUCK_N);

    logic [NPAT-1:0] hit;

    // Out-of-range pat_idx matches no slot, so the write is dropped.
    for (genvar i = 0; i < NPAT; i++) begin : g_slot
        aes_leak_guard_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .we_i    (pat_we && (pat_idx == IW'(i))),
            .wdata_i (pat_data),
            .din_i   (din),
            .en_i    (pat_en[i]),
            .hit_o   (hit[i])
        );
    end

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RW-1:0]    run_q, run_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q;
    logic             alarm_q, alarm_d;
    logic [2:0]       src_q, src_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stuck_q, stuck_d;
    logic             leak, pmatch, stk, det;
    logic [IW-1:0]    hit_idx;

    // run_q == 0 means no valid word seen since reset.
    always_comb begin
        prev_d = prev_q;
        run_d  = run_q;
        if (din_valid) begin
            prev_d = din;
            if (run_q != '0 && din == prev_q)
                run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
            else
                run_d = RW'(1);
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int i = NPAT - 1; i >= 0; i--)
            if (hit[i]) hit_idx = IW'(i);
    end

    assign leak    = din_valid && (din == key);
    assign pmatch  = din_valid && (|hit);
    assign stk     = din_valid && (run_d >= RUN_MAX);
    assign det     = leak || pmatch || stk;
    assign stuck_d = (run_d >= RUN_MAX);

    always_comb begin
        dout_d  = (det || alarm_q) ? '0 : din;
        alarm_d = alarm_q;
        src_d   = src_q;
        last_d  = pmatch ? hit_idx : last_q;
        cnt_d   = cnt_q;
        // A same-cycle clear drops the old causes but the new ones still land.
        if (det) begin
            alarm_d = 1'b1;
            src_d   = (alarm_clr ? 3'b000 : src_q) | {stk, pmatch, leak};
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (alarm_clr) begin
            alarm_d = 1'b0;
            src_d   = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= '0;
            run_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            alarm_q <= 1'b0;
            src_q   <= 3'b000;
            last_q  <= '0;
            cnt_q   <= '0;
            stuck_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            run_q   <= run_d;
            dout_q  <= dout_d;
            dv_q    <= din_valid;
            alarm_q <= alarm_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            stuck_q <= stuck_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign alarm      = alarm_q;
    assign alarm_src  = src_q;
    assign last_idx   = last_q;
    assign event_cnt  = cnt_q;
    assign stuck      = stuck_q;
endmodule

// File: tb/tb_aes_leak_guard.sv
// Bench for aes_leak_guard: directed table, corner sequences and randomized
// traffic against a rule-level reference model.

module tb_aes_leak_guard;
    localparam int W  = 128;
    localparam int NP = 4;
    localparam int SN = 8;

    localparam logic [W-1:0] KEY_A = {16{8'hAA}};
    localparam logic [W-1:0] KEY_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] PAT_P = 128'h6939b2e898f969350967325782ecc94e;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  key, din, pat_data;
    logic          din_valid, pat_we, alarm_clr;
    logic [1:0]    pat_idx;
    logic [NP-1:0] pat_en;

    logic [W-1:0]  dout, d2_dout;
    logic          dout_valid, alarm, stuck, d2_dv, d2_alarm, d2_stuck;
    logic [2:0]    alarm_src, d2_src;
    logic [1:0]    last_idx, d2_last;
    logic [15:0]   event_cnt;
    logic [1:0]    d2_cnt;

    aes_leak_guard #(.WIDTH(W), .NPAT(NP), .CNT_W(16), .STUCK_N(SN)) dut (
        .clk(clk), .rst(rst), .key(key), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .pat_we(pat_we), .pat_idx(pat_idx),
        .pat_data(pat_data), .pat_en(pat_en), .alarm_clr(alarm_clr), .alarm(alarm),
        .alarm_src(alarm_src), .last_idx(last_idx), .event_cnt(event_cnt), .stuck(stuck)
    );

    aes_leak_guard #(.WIDTH(W), .NPAT(NP), .CNT_W(2), .STUCK_N(SN)) dut2 (
        .clk(clk), .rst(rst), .key(key), .din(din), .din_valid(din_valid),
        .dout(d2_dout), .dout_valid(d2_dv), .pat_we(pat_we), .pat_idx(pat_idx),
        .pat_data(pat_data), .pat_en(pat_en), .alarm_clr(alarm_clr), .alarm(d2_alarm),
        .alarm_src(d2_src), .last_idx(d2_last), .event_cnt(d2_cnt), .stuck(d2_stuck)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", nm, act, exp);
    endtask

    // Reference model state, expressed directly in terms of the behavioural rules.
    logic [W-1:0] m_prev;
    int           m_run;
    logic [W-1:0] m_pat [NP];
    logic         m_alarm, m_dv, m_stuck;
    logic [2:0]   m_src;
    int           m_last, m_cnt, m_cnt2;
    logic [W-1:0] m_dout;

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_alarm = 0; m_dv = 0; m_stuck = 0;
        m_src = 0; m_last = 0; m_cnt = 0; m_cnt2 = 0; m_dout = '0;
        for (int i = 0; i < NP; i++) m_pat[i] = '0;
    endtask

    task automatic model_step();
        bit lk, ph, st, det;
        int hit;
        lk = 0; ph = 0; st = 0; hit = -1;
        if (rst) begin
            model_reset();
            return;
        end
        if (din_valid) begin
            if (m_run > 0 && din == m_prev) m_run = (m_run < SN) ? m_run + 1 : SN;
            else m_run = 1;
            m_prev = din;
            lk = (din == key);
            for (int i = NP - 1; i >= 0; i--)
                if (pat_en[i] && din == m_pat[i]) hit = i;
            ph = (hit >= 0);
            st = (m_run >= SN);
        end
        det     = lk | ph | st;
        m_dout  = (det || m_alarm) ? '0 : din;
        m_dv    = din_valid;
        m_stuck = (m_run >= SN);
        if (det) begin
            m_alarm = 1;
            m_src   = (alarm_clr ? 3'b000 : m_src) | {st, ph, lk};
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (alarm_clr) begin
            m_alarm = 0;
            m_src   = 0;
        end
        if (ph) m_last = hit;
        if (pat_we && pat_idx < NP) m_pat[pat_idx] = pat_data;
    endtask

    task automatic step(string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".dout"},  dout, m_dout);
        chk({tag, ".dv"},    W'(dout_valid), W'(m_dv));
        chk({tag, ".alarm"}, W'(alarm), W'(m_alarm));
        chk({tag, ".src"},   W'(alarm_src), W'(m_src));
        chk({tag, ".last"},  W'(last_idx), W'(m_last));
        chk({tag, ".cnt"},   W'(event_cnt), W'(m_cnt));
        chk({tag, ".stuck"}, W'(stuck), W'(m_stuck));
        chk({tag, ".cnt2"},  W'(d2_cnt), W'(m_cnt2));
    endtask

    typedef struct {
        logic [W-1:0] key;
        logic [W-1:0] din;
        logic         vld;
        logic         clr;
        logic [W-1:0] e_dout;
        logic         e_alarm;
        logic [2:0]   e_src;
        int           e_cnt;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [W-1:0] q, r;
        rst = 1; key = KEY_A; din = 128'h1234; din_valid = 1;
        pat_we = 0; pat_idx = 0; pat_data = '0; pat_en = '0; alarm_clr = 0;
        model_reset();

        tbl[0] = '{KEY_A, 128'h1234, 1, 0, 128'h1234, 0, 3'b000, 0};
        tbl[1] = '{KEY_K, KEY_K,     1, 0, '0,        1, 3'b001, 1};
        tbl[2] = '{KEY_K, 128'h5555, 1, 0, '0,        1, 3'b001, 1};
        tbl[3] = '{KEY_K, 128'h5555, 0, 1, '0,        0, 3'b000, 1};
        tbl[4] = '{KEY_K, 128'h7777, 1, 0, 128'h7777, 0, 3'b000, 1};

        step("rst0");
        step("rst1");
        chk("rst_dout", dout, '0);
        chk("rst_alarm", W'(alarm), '0);
        chk("rst_cnt", W'(event_cnt), '0);
        rst = 0;

        for (int i = 0; i < 5; i++) begin
            key = tbl[i].key; din = tbl[i].din;
            din_valid = tbl[i].vld; alarm_clr = tbl[i].clr;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("tbl%0d_alarm", i), W'(alarm), W'(tbl[i].e_alarm));
            chk($sformatf("tbl%0d_src", i), W'(alarm_src), W'(tbl[i].e_src));
            chk($sformatf("tbl%0d_cnt", i), W'(event_cnt), W'(tbl[i].e_cnt));
        end
        alarm_clr = 0;

        // Pattern slot 2
        din_valid = 0; pat_we = 1; pat_idx = 2; pat_data = PAT_P;
        step("pw");
        pat_we = 0; pat_en = 4'b0100; din = PAT_P; din_valid = 1;
        step("phit");
        chk("phit_dout", dout, '0);
        chk("phit_src", W'(alarm_src), W'(3'b010));
        chk("phit_last", W'(last_idx), W'(2'd2));
        din_valid = 0; alarm_clr = 1;
        step("pclr");
        alarm_clr = 0; pat_en = 4'b0000; din_valid = 1;
        step("pdis");
        chk("pdis_dout", dout, PAT_P);

        // Stuck: eight identical words with gaps
        for (int k = 1; k <= SN; k++) begin
            din = {4{32'h5A5A_C3C3}}; din_valid = 1;
            step("stk");
            chk($sformatf("stuck_w%0d", k), W'(stuck), W'(k == SN));
            din_valid = 0;
            step("gap");
        end
        chk("stuck_src2", W'(alarm_src[2]), 1);
        din = 128'h9999; din_valid = 1;
        step("stkdrop");
        chk("stuck_drop", W'(stuck), 0);

        // Clear and leak together
        din = KEY_K; alarm_clr = 1;
        step("clrleak");
        chk("clrleak_alarm", W'(alarm), 1);
        chk("clrleak_src", W'(alarm_src), W'(3'b001));
        din_valid = 0;
        step("clr2");
        alarm_clr = 0;

        // Pattern write coinciding with matching word
        q = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        pat_we = 1; pat_idx = 0; pat_data = q; pat_en = 4'b0001; din = q; din_valid = 1;
        step("wsame");
        chk("wsame_alarm", W'(alarm), 0);
        pat_we = 0;
        step("wnext");
        chk("wnext_src", W'(alarm_src), W'(3'b010));
        chk("wnext_last", W'(last_idx), 0);

        // Saturation and mid-run reset
        din_valid = 0; rst = 1;
        step("rstA");
        rst = 0; din = KEY_K; din_valid = 1;
        for (int k = 0; k < 5; k++) step("sat");
        chk("sat_cnt2", W'(d2_cnt), 3);
        chk("sat_cnt16", W'(event_cnt), 5);
        rst = 1;
        #2;
        chk("midrst_dout", dout, '0);
        chk("midrst_cnt", W'(event_cnt), '0);
        chk("midrst_stuck", W'(stuck), '0);
        step("midrst");
        rst = 0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r8;
            rst = ($urandom_range(0, 149) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
            alarm_clr = ($urandom_range(0, 5) == 0);
            pat_we = ($urandom_range(0, 7) == 0);
            pat_idx = 2'($urandom_range(0, 3));
            pat_data = {$urandom, $urandom, $urandom, $urandom};
            pat_en = 4'($urandom);
            if ($urandom_range(0, 49) == 0) key = {$urandom, $urandom, $urandom, $urandom};
            r8 = $urandom_range(0, 7);
            if (r8 == 0) din = key;
            else if (r8 == 1) din = m_pat[$urandom_range(0, NP - 1)];
            else if (r8 <= 4) din = din;
            else begin
                r = {$urandom, $urandom, $urandom, $urandom};
                din = r;
            end
            step($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
